// File: rtl/ram_block_mover_pkg.sv
// Shared definitions for the RAM block mover: FSM encoding and width helpers.
package ram_block_mover_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam int DATA_W = 32;

  // Word counter must hold 0..D inclusive.
  function automatic int len_w(input int aw);
    return aw + 1;
  endfunction

  // Range sums (addr + length) need one more bit than the counter.
  function automatic int sum_w(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/ram_block_mover_ptr.sv
// Loadable up/down address pointer; one instance each for source and destination.
module ram_block_mover_ptr
  import ram_block_mover_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         down,
  output logic [W-1:0] ptr_q,
  output logic [W-1:0] ptr_d
);

  // Next pointer: load wins over step; step direction chosen by down.
  always_comb begin
    ptr_d = ptr_q;
    if (load)
      ptr_d = load_val;
    else if (step)
      ptr_d = down ? (ptr_q - W'(1)) : (ptr_q + W'(1));
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sync_ram.sv
// Single-port 32-bit RAM: synchronous write, combinational read gated by read.
module sync_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           Din,
  input  logic                  writeEn,
  input  logic                  read,
  output wire  [31:0]           Dout
);

  logic [31:0] mem [1<<ADDR_WIDTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (writeEn) mem[addr] <= Din;
  end

  assign Dout = read ? mem[addr] : {32{1'bz}};

endmodule

// File: rtl/ram_block_mover.sv
// Copies a block of words inside a single-port sync RAM with memmove semantics.
// Two cycles per word (READ then WRITE); direction chosen at start so that
// overlapping regions are copied without clobbering unread source words.
module ram_block_mover
  import ram_block_mover_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  output logic                  ram_write_en,
  output logic                  ram_read,
  input  logic [DATA_W-1:0]     ram_dout
);

  localparam int LEN_W = len_w(ADDR_WIDTH);
  localparam int SUM_W = sum_w(ADDR_WIDTH);
  localparam logic [SUM_W-1:0] DEPTH = SUM_W'(1) << ADDR_WIDTH;

  state_e                  state_q, state_d;
  logic                    dir_down_q, dir_down_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]       ram_din_q, ram_din_d;
  logic                    ram_we_q, ram_we_d;
  logic                    ram_rd_q, ram_rd_d;

  logic [SUM_W-1:0]        src_end, dst_end;
  logic                    len_zero, range_bad, idle_req, accept, reject, desc;
  logic [ADDR_WIDTH-1:0]   src_load, dst_load;
  logic [ADDR_WIDTH-1:0]   src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic                    ptr_step;

  // Request validation; sums are wide enough that addr+length never wraps.
  always_comb begin
    src_end   = SUM_W'(src_addr) + SUM_W'(length);
    dst_end   = SUM_W'(dst_addr) + SUM_W'(length);
    len_zero  = (length == '0);
    range_bad = (src_end > DEPTH) || (dst_end > DEPTH);
    idle_req  = (state_q == ST_IDLE) && start;
    accept    = idle_req && !len_zero && !range_bad;
    reject    = idle_req && !len_zero && range_bad;
    desc      = (dst_addr > src_addr);
    src_load  = desc ? (src_addr + ADDR_WIDTH'(length - LEN_W'(1))) : src_addr;
    dst_load  = desc ? (dst_addr + ADDR_WIDTH'(length - LEN_W'(1))) : dst_addr;
    ptr_step  = (state_q == ST_WRITE);
  end

  ram_block_mover_ptr #(.W(ADDR_WIDTH)) u_src_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (src_load),
    .step     (ptr_step),
    .down     (dir_down_q),
    .ptr_q    (src_ptr_q),
    .ptr_d    (src_ptr_d)
  );

  ram_block_mover_ptr #(.W(ADDR_WIDTH)) u_dst_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (dst_load),
    .step     (ptr_step),
    .down     (dir_down_q),
    .ptr_q    (dst_ptr_q),
    .ptr_d    (dst_ptr_d)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: READ/WRITE alternate until the last word is written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (idle_req && len_zero) state_d = ST_FIN;
                else if (accept)          state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = (rem_q == LEN_W'(1)) ? ST_FIN : ST_READ;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: direction latch, word counter, read-data capture.
  always_comb begin
    dir_down_d = accept ? desc : dir_down_q;
    rem_d      = rem_q;
    if (accept)                   rem_d = length;
    else if (state_q == ST_WRITE) rem_d = rem_q - LEN_W'(1);
    // RAM data is only valid while ram_read is high, i.e. in READ.
    data_d     = (state_q == ST_READ) ? ram_dout : data_q;
  end

  // Output logic: registered from the state being entered so outputs are Moore.
  always_comb begin
    busy_d     = (state_d == ST_READ) || (state_d == ST_WRITE);
    done_d     = (state_d == ST_FIN);
    error_d    = reject;
    ram_rd_d   = (state_d == ST_READ);
    ram_we_d   = (state_d == ST_WRITE);
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if (state_d == ST_READ)  ram_addr_d = src_ptr_d;
    if (state_d == ST_WRITE) begin
      ram_addr_d = dst_ptr_d;
      ram_din_d  = data_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_down_q <= 1'b0;
      rem_q      <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_rd_q   <= 1'b0;
    end else begin
      dir_down_q <= dir_down_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      ram_rd_q   <= ram_rd_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign ram_addr     = ram_addr_q;
  assign ram_din      = ram_din_q;
  assign ram_write_en = ram_we_q;
  assign ram_read     = ram_rd_q;

endmodule

// File: tb/tb_ram_block_mover.sv
// Self-checking bench for ram_block_mover against a memmove reference model.
module tb_ram_block_mover;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0;
  logic [LW-1:0] length = '0;
  wire           busy, done, error;
  wire  [AW-1:0] mv_addr;
  wire  [31:0]   mv_din;
  wire           mv_we, mv_rd;

  logic          tb_own = 1'b1;
  logic [AW-1:0] tb_addr = '0;
  logic [31:0]   tb_din = '0;
  logic          tb_we = 1'b0, tb_rd = 1'b0;

  wire  [AW-1:0] r_addr = tb_own ? tb_addr : mv_addr;
  wire  [31:0]   r_din  = tb_own ? tb_din  : mv_din;
  wire           r_we   = tb_own ? tb_we   : mv_we;
  wire           r_rd   = tb_own ? tb_rd   : mv_rd;
  wire  [31:0]   r_dout;

  int checks = 0, errors = 0;
  int acc_cnt = 0;
  logic [31:0] model [D];
  logic [31:0] last_rd = '0;
  logic        have_rd = 1'b0;

  ram_block_mover #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .error(error),
    .ram_addr(mv_addr), .ram_din(mv_din), .ram_write_en(mv_we),
    .ram_read(mv_rd), .ram_dout(r_dout)
  );

  sync_ram #(.ADDR_WIDTH(AW)) u_ram (
    .clk(clk), .addr(r_addr), .Din(r_din), .writeEn(r_we),
    .read(r_rd), .Dout(r_dout)
  );

  always #5 clk = ~clk;

  // Protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    checks++;
    if (mv_rd && mv_we) begin
      errors++;
      $display("FAIL rd_we_excl: read=%0b write_en=%0b, required not both 1", mv_rd, mv_we);
    end
    if (reset) have_rd = 1'b0;
    else if (!tb_own) begin
      if (mv_rd || mv_we) acc_cnt++;
      if (mv_rd) begin
        last_rd = r_dout;
        have_rd = 1'b1;
      end
      if (mv_we) begin
        checks++;
        if (!have_rd || mv_din !== last_rd) begin
          errors++;
          $display("FAIL write_data: din=%08h required %08h (have_rd=%0b)", mv_din, last_rd, have_rd);
        end
        have_rd = 1'b0;
      end
    end
  end

  // Fill RAM (and model) through the bench-owned port.
  task automatic load_mem(input bit rnd, input int base);
    tb_own = 1'b1;
    for (int i = 0; i < D; i++) begin
      @(posedge clk); #1;
      tb_addr  = AW'(i);
      tb_din   = rnd ? $urandom : 32'(base + i);
      tb_we    = 1'b1;
      model[i] = tb_din;
    end
    @(posedge clk); #1;
    tb_we = 1'b0;
    tb_own = 1'b0;
  endtask

  task automatic check_mem(input string name);
    tb_own = 1'b1;
    tb_rd  = 1'b1;
    for (int i = 0; i < D; i++) begin
      tb_addr = AW'(i);
      #1;
      checks++;
      if (r_dout !== model[i]) begin
        errors++;
        $display("FAIL %s mem[%0d]: got %08h required %08h", name, i, r_dout, model[i]);
      end
    end
    tb_rd  = 1'b0;
    tb_own = 1'b0;
  endtask

  // Reference memmove: snapshot the source first, then write.
  task automatic model_move(input int s, input int d, input int l);
    logic [31:0] tmp [D];
    for (int i = 0; i < l; i++) tmp[i] = model[s + i];
    for (int i = 0; i < l; i++) model[d + i] = tmp[i];
  endtask

  // Issue one request and record when done/error/busy appear.
  task automatic do_req(input int s, input int d, input int l, input int poke,
                        output int done_cyc, output int err_cyc,
                        output int busy_cyc, output int done_n);
    @(posedge clk); #1;
    src_addr = AW'(s);
    dst_addr = AW'(d);
    length   = LW'(l);
    start    = 1'b1;
    acc_cnt  = 0;
    @(posedge clk); #1;
    start    = 1'b0;
    src_addr = AW'($urandom);
    dst_addr = AW'($urandom);
    length   = LW'($urandom);
    done_cyc = -1; err_cyc = -1; busy_cyc = 0; done_n = 0;
    for (int n = 1; n <= 2 * l + 4; n++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (error && err_cyc < 0) err_cyc = n;
      if (n == poke) begin
        start = 1'b1; src_addr = '0; dst_addr = '0; length = '0;
      end else if (n == poke + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic expect_copy(input string name, input int s, input int d, input int l,
                             input int poke);
    int dc, ec, bc, dn;
    do_req(s, d, l, poke, dc, ec, bc, dn);
    model_move(s, d, l);
    checks++;
    if (dc != 2 * l + 1 || dn != 1) begin
      errors++;
      $display("FAIL %s done: cycle %0d pulses %0d, required cycle %0d pulses 1", name, dc, dn, 2 * l + 1);
    end
    checks++;
    if (bc != 2 * l || ec != -1) begin
      errors++;
      $display("FAIL %s busy/error: busy %0d err %0d, required busy %0d err -1", name, bc, ec, 2 * l);
    end
    check_mem(name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, error, mv_we, mv_rd} !== 5'b0 || mv_addr !== '0 || mv_din !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%0b done=%0b err=%0b we=%0b rd=%0b addr=%0h din=%0h, required all 0",
               busy, done, error, mv_we, mv_rd, mv_addr, mv_din);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_ascending();
    load_mem(1'b0, 32'hA0);
    expect_copy("ascending", 0, 8, 4, 3);
  endtask

  task automatic test_overlap();
    load_mem(1'b1, 0);
    expect_copy("overlap_up", 2, 4, 4, 0);
    load_mem(1'b1, 0);
    expect_copy("overlap_down", 4, 2, 4, 0);
  endtask

  task automatic test_len_zero();
    int dc, ec, bc, dn;
    load_mem(1'b1, 0);
    do_req(3, 7, 0, 0, dc, ec, bc, dn);
    checks++;
    if (dc != 1 || dn != 1 || bc != 0 || ec != -1 || acc_cnt != 0) begin
      errors++;
      $display("FAIL len_zero: done %0d/%0d busy %0d err %0d acc %0d, required 1/1 0 -1 0", dc, dn, bc, ec, acc_cnt);
    end
    check_mem("len_zero");
  endtask

  task automatic test_range_error(input int s, input int d, input int l);
    int dc, ec, bc, dn;
    load_mem(1'b1, 0);
    do_req(s, d, l, 0, dc, ec, bc, dn);
    checks++;
    if (ec != 1 || dn != 0 || bc != 0 || acc_cnt != 0) begin
      errors++;
      $display("FAIL range_error s=%0d d=%0d l=%0d: err %0d done %0d busy %0d acc %0d, required 1 0 0 0",
               s, d, l, ec, dn, bc, acc_cnt);
    end
    check_mem("range_error");
  endtask

  task automatic test_full_depth();
    load_mem(1'b1, 0);
    expect_copy("full_depth", 0, 0, D, 5);
  endtask

  task automatic test_mid_reset();
    int dn;
    load_mem(1'b1, 0);
    @(posedge clk); #1;
    src_addr = AW'(8); dst_addr = AW'(0); length = LW'(6); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, error, mv_we, mv_rd} !== 5'b0 || mv_addr !== '0 || mv_din !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%0b done=%0b err=%0b we=%0b rd=%0b addr=%0h din=%0h, required all 0",
               busy, done, error, mv_we, mv_rd, mv_addr, mv_din);
    end
    reset = 1'b0;
    dn = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: %0d cycles with done/busy, required 0", dn);
    end
    model[0] = model[8];
    model[1] = model[9];
    check_mem("mid_reset");
  endtask

  task automatic test_random();
    int l, s, d;
    for (int k = 0; k < 8; k++) begin
      l = $urandom_range(D, 1);
      s = $urandom_range(D - l, 0);
      d = $urandom_range(D - l, 0);
      load_mem(1'b1, 0);
      expect_copy("random", s, d, l, (k % 2 == 0) ? 2 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      l = $urandom_range(D, 2);
      s = $urandom_range(D - 1, D - l + 1);
      test_range_error(s, $urandom_range(D - 1, 0), l);
      test_range_error($urandom_range(D - l, 0), s, l);
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_overlap();
    test_len_zero();
    test_range_error(12, 0, 5);
    test_full_depth();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_block_mover.md
Name: ram_block_mover

Overview:
- Initiator-side engine for the single-port 32-bit sync RAM: drives addr/Din/writeEn/read and consumes Dout.
- Copies a block of LENGTH words from SRC to DST inside that RAM, with memmove semantics for overlapping regions.
- Sits between the control/sequencer logic and the RAM; only one transfer is in flight at a time.

Parameters:
- ADDR_WIDTH, 10, RAM address width; RAM depth D = 1 << ADDR_WIDTH

Ports:
- clk  in  1  clock; everything is posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  ADDR_WIDTH  first source word
- dst_addr  in  ADDR_WIDTH  first destination word
- length  in  ADDR_WIDTH+1  word count, 0..D
- busy  out  1  high from the cycle after an accepted start until done/error
- done  out  1  one-cycle pulse when the transfer completes
- error  out  1  one-cycle pulse when a request is rejected
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_din  out  32  to RAM Din
- ram_write_en  out  1  to RAM writeEn
- ram_read  out  1  to RAM read
- ram_dout  in  32  from RAM Dout; combinational read data, Z when ram_read=0

Behaviour:
- Reset values:
  - busy, done, error, ram_write_en and ram_read are 0.
  - ram_addr and ram_din are 0.
  - FSM state is IDLE; internal pointers, counter and data register are cleared.
- Reset mid-transfer: the FSM returns to IDLE at that edge and no done pulse follows. Words already written stay in RAM.
- FSM states: IDLE, READ, WRITE, FIN.
- IDLE, start=1, request validated in the same cycle:
  - length==0: go to FIN. No RAM access occurs.
  - src_addr+length > D or dst_addr+length > D: pulse error next cycle and stay in IDLE. Compute both sums at ADDR_WIDTH+2 bits.
  - Otherwise latch the request and set busy. Enter READ.
- Copy direction is latched at start:
  - dst_addr > src_addr: descending. src_ptr = src+len-1, dst_ptr = dst+len-1, and the pointers decrement.
  - Otherwise: ascending from src/dst, and the pointers increment.
  - The counter remaining = length.
- READ (one cycle):
  - ram_read=1, ram_addr=src_ptr, ram_write_en=0.
  - At the edge, ram_dout is captured into data_reg. It is never sampled when ram_read=0.
  - Go to WRITE.
- WRITE (one cycle):
  - ram_write_en=1, ram_addr=dst_ptr, ram_din=data_reg, ram_read=0.
  - At the edge, step both pointers and decrement remaining.
  - If remaining was 1, go to FIN; else go to READ.
- FIN (one cycle): done=1, busy=0. Go to IDLE.
- RAM outputs are registered per state (Moore). ram_read and ram_write_en are never high in the same cycle.
- Throughput: 2 cycles per word.
  - Latency from the start edge to the done pulse is 2*length+1 cycles.
  - For length 0, done is asserted the cycle after start.
- src==dst is legal. Each word is rewritten with its own value.
- start while busy is ignored: no error, no queueing.
- Inputs src_addr/dst_addr/length may change after acceptance without effect.
- A full-depth copy (length==D, src=dst=0) is legal. The counter needs ADDR_WIDTH+1 bits.
- Pointer wrap never occurs because of the range check. The last step past D-1 or below 0 is don't-care.

Decomposition:
- A shared package holds:
  - FSM state encoding (IDLE/READ/WRITE/FIN, 2 bits).
  - Width helper constants derived from ADDR_WIDTH, e.g. LEN_W = ADDR_WIDTH+1.
- Sub-module ram_block_mover_ptr: a loadable up/down counter. Instantiated twice (src, dst), with direction and step inputs.
- The bench instantiates sync_ram (ADDR_WIDTH=4) connected to the mover's RAM port.

Test Plan:
- Ascending copy. Preload mem[0..3]=A0..A3, start src=0, dst=8, len=4 -> mem[8..11]=A0..A3 and source unchanged. done exactly 9 cycles after the start edge; busy high for 8 cycles.
- Overlap, dst>src. mem[2..5]=1,2,3,4, start src=2, dst=4, len=4 -> mem[4..7]=1,2,3,4 (descending order verified). Overlap, dst<src: src=4, dst=2, len=4 with mem[4..7]=5,6,7,8 -> mem[2..5]=5,6,7,8.
- Boundaries. len=0 -> done the next cycle, ram_read and ram_write_en never asserted. src=12, len=5 (D=16) -> error pulse, no RAM access, busy stays 0. src=0, dst=0, len=16 -> done after 33 cycles, contents unchanged.
- Protocol checks (SVA-style, every cycle):
  - ram_read and ram_write_en are never both 1.
  - The data written equals the RAM value read on the preceding READ cycle.
  - ram_dout is not sampled when ram_read=0 (Z is never captured).
- Reset and busy start. Assert reset after 2 words of a len=6 copy -> outputs zero at the next edge, done never pulses, and only the first 2 destination words are updated. start pulsed while busy is ignored, and the original transfer completes normally.
